// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr
// Registered N-way request arbiter with a valid/ready grant handshake.
// It chooses one requester either by fixed priority (the highest index wins)
// or by round-robin (the search starts at ptr and moves downward, wrapping
// from 0 to N-1). The chosen grant is latched and held until the consumer
// accepts it.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req          request vector, bit i = requester i wants service
//   rr_en        0 = fixed priority, 1 = round-robin (sampled when arbitrating)
//   grant_ready  consumer accepts the held grant
//   grant_valid  a grant is being held
//   grant_idx    binary index of the granted requester (0 when idle)
//   grant_onehot one-hot form of grant_idx (0 when idle)
//   ptr          current highest-priority index for round-robin
module prio_arbiter_rr #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         rr_en,
    input  logic         grant_ready,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] ptr
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [W-1:0]   idx_d;
    logic [N-1:0]   onehot_d;
    logic [W-1:0]   ptr_d;
    logic [W-1:0]   fixed_win;
    logic [W-1:0]   rr_win;
    logic [W-1:0]   win;

    // Fixed priority: scan upward so that the highest set request is the
    // last one to overwrite the winner.
    always_comb begin
        logic [N-1:0] shifted;
        fixed_win = '0;
        shifted   = '0;
        for (int i = 0; i < N; i++) begin
            shifted = req >> i;
            if (shifted[0]) begin
                fixed_win = i[W-1:0];
            end
        end
    end

    // Round-robin: visit positions ptr, ptr-1, ... wrapping modulo N (never
    // modulo 2^W). We walk from the farthest distance to the nearest so the
    // set request closest below ptr is the last one to be written.
    always_comb begin
        logic [N-1:0] shifted;
        int           j;
        rr_win  = '0;
        shifted = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) - k;
            if (j < 0) begin
                j = j + N;
            end
            shifted = req >> j;
            if (shifted[0]) begin
                rr_win = j[W-1:0];
            end
        end
    end

    assign win = rr_en ? rr_win : fixed_win;

    // Next-state logic. In IDLE any request triggers arbitration. In GRANT
    // the outputs stay frozen, whatever req does, until the consumer accepts.
    // On accept the priority pointer moves to just below the accepted index.
    always_comb begin
        state_d  = state;
        idx_d    = grant_idx;
        onehot_d = grant_onehot;
        ptr_d    = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d  = GRANT;
                    idx_d    = win;
                    onehot_d = N'(1) << win;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    onehot_d = '0;
                    ptr_d    = (grant_idx == '0) ? W'(N - 1) : grant_idx - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears the grant at once, without
    // waiting for a clock edge, and points round-robin at the top requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant_idx    <= '0;
            grant_onehot <= '0;
            ptr          <= W'(N - 1);
        end else begin
            state        <= state_d;
            grant_idx    <= idx_d;
            grant_onehot <= onehot_d;
            ptr          <= ptr_d;
        end
    end

    // A grant is held exactly while the FSM is in GRANT, so grant_valid is a
    // decode of the state register and has no combinational input path.
    assign grant_valid = (state == GRANT);

endmodule
